arb_rr: RTL and testbench
=========================

# arb_rr

Parametrised round-robin arbiter multiplexing N requester ports onto one memory-side master port. Successor to the fixed 4-port arbiter: channel count, address and data widths are parameters, an explicit grant vector is exported, idle outputs are fully defined, and a withdrawn request is handled. It sits between the requester cores and the shared memory/bus interface.

## Interface
- `N`, 4: number of requesters, ≥2.
- `AW`, 64: address width.
- `DW`, 64: data width.
- `TIMEOUT`, 256: maximum cycles in BUSY before an abort (used only with `ARB_TIMEOUT_EN`), ≥2.
- `clk` in 1: clock, rising edge.
- `reset_n` in 1: asynchronous active-low reset.
- `addr_a` in N*AW: requester i address at `[i*AW +: AW]`.
- `dout_a` in N*DW: requester i write data at `[i*DW +: DW]`.
- `din_a` out N*DW: read data; `din_m` broadcast to every slice.
- `req_a` in N: request level per requester.
- `wr_a` in N: write qualifier per requester.
- `rdy_a` out N: one-hot completion strobe.
- `gnt_a` out N: one-hot current owner; all zero when idle.
- `err_a` out N: one-hot timeout-abort strobe; tied 0 without `ARB_TIMEOUT_EN`.
- `addr_m` out AW, `dout_m` out DW, `req_m` out 1, `wr_m` out 1: master-side request.
- `din_m` in DW: master read data.
- `rdy_m` in 1: master completion, one-cycle pulse.

## Operation
- State: `IDLE`, `BUSY`. Registers: `cur` ($clog2(N) bits), `last` ($clog2(N) bits), `state`.
- IDLE: if any `req_a` bit set, winner = first set bit scanning `last+1, last+2, … last+N` mod N; `cur`<=winner, `state`<=BUSY. No request: stay.
- BUSY: `gnt_a`=1<<cur; `addr_m`, `dout_m`, `wr_m` = slice `cur`; `req_m`=`req_a[cur]`; `rdy_a`=`rdy_m` ? 1<<cur : 0 (combinational).
- BUSY and `rdy_m`=1: `last`<=cur, `state`<=IDLE.
- BUSY, `req_a[cur]`=0 and `rdy_m`=0 (withdrawal): `state`<=IDLE, `last` unchanged; no `rdy_a`.
- `rdy_m` together with a withdrawal: completion wins (`rdy_a` pulses, `last` updated).
- IDLE: `addr_m`, `dout_m`, `req_m`, `wr_m`, `rdy_a`, `gnt_a` all 0; `rdy_m` in IDLE ignored.
- Modulo arithmetic valid for non-power-of-two N: wrap by compare-and-subtract, not truncation.
- `din_a` is pure wiring, valid only while `rdy_a` bit is set.

## Timing
- Reset (asynchronous assert, synchronous release): `state`=IDLE, `cur`=0, `last`=N-1, all outputs 0 except `din_a`=replicated `din_m`.
- Arbitration latency: request seen in cycle t -> `gnt_a`/`req_m` high in cycle t+1.
- Completion: `rdy_m` in cycle t -> `rdy_a` in cycle t; IDLE in t+1; next grant earliest t+2 (one idle bubble between transactions).
- A requester must hold `req_a`, `addr_a`, `dout_a`, `wr_a` stable until its `rdy_a`.
- Reset mid-transaction: grant drops immediately; the in-flight master access is the master's responsibility.

## Configuration
- `ARB_TIMEOUT_EN` defined: counter `tcnt` ($clog2(TIMEOUT+1) bits) cleared on IDLE->BUSY, increments each BUSY cycle without `rdy_m`; when `tcnt`==TIMEOUT-1 and `rdy_m`=0: `err_a`=1<<cur for that cycle, `req_m` still high that cycle, `last`<=cur, `state`<=IDLE. `rdy_m` on that same cycle is a normal completion, no error.
- Not defined: no counter, `err_a`=0, BUSY held indefinitely.

## Structure
- Shared package `arb_pkg`: state enum (`ARB_IDLE`, `ARB_BUSY`) and an index-width function.
- One sub-module `rr_pick`: combinational N-bit round-robin picker (inputs `req`, `last`; outputs `valid`, `idx`); reused by future arbiters.

## Test plan
- N=4, reset release, `req_a`=4'b1111 -> `gnt_a`=0001 next cycle; rdy_m pulses give order 0,1,2,3,0, one idle cycle between grants.
- N=3, `req_a`=3'b101, `last`=2 after reset -> grant 0, then 2, then 0 (wrap with non-power-of-two).
- Grant to 1 with `addr_a[1]`=0x1234, `wr_a[1]`=1 -> `addr_m`=0x1234, `wr_m`=1; `rdy_m` -> `rdy_a`=0010 same cycle.
- Requester 2 drops `req_a[2]` while BUSY -> IDLE next cycle, no `rdy_a`, next grant scans from old `last`+1.
- `ARB_TIMEOUT_EN`, TIMEOUT=8, `rdy_m` never asserted -> `err_a[cur]` pulses exactly in 8th BUSY cycle, IDLE after; `rdy_m` in that cycle -> `rdy_a` only.
- `reset_n` low mid-BUSY, asynchronous to `clk` -> `gnt_a`, `req_m` 0 immediately; after release first grant goes to requester 0.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared definitions for the round-robin arbiter family.
//   arb_state_t : arbiter FSM state (ARB_IDLE / ARB_BUSY)
//   idx_w(n)    : bit width of an index into n requesters (at least 1)
package arb_pkg;

    typedef enum logic {
        ARB_IDLE = 1'b0,
        ARB_BUSY = 1'b1
    } arb_state_t;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational N-way round-robin picker.
//   req   in  N     : request vector
//   last  in  IW    : index served most recently (lowest priority now)
//   valid out 1     : at least one request present
//   idx   out IW    : first set request scanning last+1 .. last+N (mod N)
// Wrap uses compare-and-subtract so non-power-of-two N is handled.
module rr_pick
    import arb_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_w(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last,
    output logic          valid,
    output logic [IW-1:0] idx
);

    // base < N and off <= N, so a single subtraction is enough to wrap.
    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= N) s = s - N;
        return IW'(s);
    endfunction

    always_comb begin
        valid = |req;
        idx   = '0;
        // Scan from farthest to nearest so the nearest slot after 'last' overwrites.
        for (int i = N; i >= 1; i--) begin
            if (req[wrap_add(last, i)]) idx = wrap_add(last, i);
        end
    end

endmodule

// File: rtl/arb_rr.sv
// Round-robin arbiter: N requester ports onto one master port.
// Optional feature macro: ARB_TIMEOUT_EN (abort a BUSY access after TIMEOUT cycles).
// Ports:
//   clk, reset_n                 : clock, async active-low reset
//   addr_a/dout_a/req_a/wr_a     : requester-side request (slice i = requester i)
//   din_a                        : read data, din_m replicated to every slice
//   rdy_a/gnt_a/err_a            : one-hot completion, owner, timeout-abort
//   addr_m/dout_m/req_m/wr_m     : master-side request (zero while idle)
//   din_m, rdy_m                 : master read data and completion pulse
module arb_rr
    import arb_pkg::*;
#(
    parameter int N       = 4,
    parameter int AW      = 64,
    parameter int DW      = 64,
    parameter int TIMEOUT = 256
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [N*AW-1:0] addr_a,
    input  logic [N*DW-1:0] dout_a,
    output logic [N*DW-1:0] din_a,
    input  logic [N-1:0]    req_a,
    input  logic [N-1:0]    wr_a,
    output logic [N-1:0]    rdy_a,
    output logic [N-1:0]    gnt_a,
    output logic [N-1:0]    err_a,
    output logic [AW-1:0]   addr_m,
    output logic [DW-1:0]   dout_m,
    output logic            req_m,
    output logic            wr_m,
    input  logic [DW-1:0]   din_m,
    input  logic            rdy_m
);

    localparam int IW = idx_w(N);

    if (N < 2 || TIMEOUT < 2) begin : g_bad_param
        $error("arb_rr: N and TIMEOUT must both be at least 2");
    end

    arb_state_t    state, state_d;
    logic [IW-1:0] cur, cur_d;
    logic [IW-1:0] last, last_d;
    logic          pick_valid;
    logic [IW-1:0] pick_idx;

`ifdef ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tcnt, tcnt_d;
`endif

    rr_pick #(.N(N)) u_pick (
        .req   (req_a),
        .last  (last),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign din_a = {N{din_m}};

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ARB_IDLE;
            cur   <= '0;
            last  <= IW'(N - 1);   // first scan after reset starts at requester 0
`ifdef ARB_TIMEOUT_EN
            tcnt  <= '0;
`endif
        end else begin
            state <= state_d;
            cur   <= cur_d;
            last  <= last_d;
`ifdef ARB_TIMEOUT_EN
            tcnt  <= tcnt_d;
`endif
        end
    end

    always_comb begin
        state_d = state;
        cur_d   = cur;
        last_d  = last;
`ifdef ARB_TIMEOUT_EN
        tcnt_d  = tcnt;
`endif
        gnt_a   = '0;
        rdy_a   = '0;
        err_a   = '0;
        addr_m  = '0;
        dout_m  = '0;
        req_m   = 1'b0;
        wr_m    = 1'b0;

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    cur_d   = pick_idx;
                    state_d = ARB_BUSY;
`ifdef ARB_TIMEOUT_EN
                    tcnt_d  = '0;
`endif
                end
            end
            ARB_BUSY: begin
                gnt_a[cur] = 1'b1;
                addr_m     = addr_a[int'(cur)*AW +: AW];
                dout_m     = dout_a[int'(cur)*DW +: DW];
                req_m      = req_a[cur];
                wr_m       = wr_a[cur];
`ifdef ARB_TIMEOUT_EN
                tcnt_d     = tcnt + 1'b1;
`endif
                // Completion beats both timeout and withdrawal in the same cycle.
                if (rdy_m) begin
                    rdy_a[cur] = 1'b1;
                    last_d     = cur;
                    state_d    = ARB_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tcnt == TW'(TIMEOUT - 1)) begin
                    err_a[cur] = 1'b1;
                    last_d     = cur;
                    state_d    = ARB_IDLE;
                end
`endif
                else if (!req_a[cur]) begin
                    // Withdrawn request: release the bus without moving priority.
                    state_d = ARB_IDLE;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

endmodule

// File: tb/tb_arb_rr.sv
// Self-checking bench for arb_rr: a 4-port and a 3-port instance share clock
// and reset. Expected grant orders are queued up front and popped on rdy_a.
module tb_arb_rr;

    localparam int AW4 = 16, DW4 = 16, AW3 = 8, DW3 = 8, TO = 8;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [4*AW4-1:0] addr_a4;
    logic [4*DW4-1:0] dout_a4, din_a4;
    logic [3:0]       req_a4, wr_a4, rdy_a4, gnt_a4, err_a4;
    logic [AW4-1:0]   addr_m4;
    logic [DW4-1:0]   dout_m4, din_m4;
    logic             req_m4, wr_m4, rdy_m4;

    logic [3*AW3-1:0] addr_a3;
    logic [3*DW3-1:0] dout_a3, din_a3;
    logic [2:0]       req_a3, wr_a3, rdy_a3, gnt_a3, err_a3;
    logic [AW3-1:0]   addr_m3;
    logic [DW3-1:0]   dout_m3, din_m3;
    logic             req_m3, wr_m3, rdy_m3;

    arb_rr #(.N(4), .AW(AW4), .DW(DW4), .TIMEOUT(TO)) dut4 (
        .clk(clk), .reset_n(rst_n), .addr_a(addr_a4), .dout_a(dout_a4), .din_a(din_a4),
        .req_a(req_a4), .wr_a(wr_a4), .rdy_a(rdy_a4), .gnt_a(gnt_a4), .err_a(err_a4),
        .addr_m(addr_m4), .dout_m(dout_m4), .req_m(req_m4), .wr_m(wr_m4),
        .din_m(din_m4), .rdy_m(rdy_m4)
    );

    arb_rr #(.N(3), .AW(AW3), .DW(DW3), .TIMEOUT(TO)) dut3 (
        .clk(clk), .reset_n(rst_n), .addr_a(addr_a3), .dout_a(dout_a3), .din_a(din_a3),
        .req_a(req_a3), .wr_a(wr_a3), .rdy_a(rdy_a3), .gnt_a(gnt_a3), .err_a(err_a3),
        .addr_m(addr_m3), .dout_m(dout_m3), .req_m(req_m3), .wr_m(wr_m3),
        .din_m(din_m3), .rdy_m(rdy_m3)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int exp_q[$];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_reset;
        rst_n   = 1'b0;
        addr_a4 = '0; dout_a4 = '0; req_a4 = '0; wr_a4 = '0; din_m4 = '0; rdy_m4 = 1'b0;
        addr_a3 = '0; dout_a3 = '0; req_a3 = '0; wr_a3 = '0; din_m3 = '0; rdy_m3 = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        do_reset;
        din_m4 = 16'hBEEF;
        din_m3 = 8'h3C;
        #1;
        n_cmp++; if (gnt_a4 !== 4'b0000) begin n_bad++; $display("FAIL reset_gnt4 got %b want 0000", gnt_a4); end
        n_cmp++; if ({req_m4, wr_m4} !== 2'b00) begin n_bad++; $display("FAIL reset_req_wr4 got %b want 00", {req_m4, wr_m4}); end
        n_cmp++; if ({rdy_a4, err_a4} !== 8'h00) begin n_bad++; $display("FAIL reset_rdy_err4 got %h want 00", {rdy_a4, err_a4}); end
        n_cmp++; if ({addr_m4, dout_m4} !== 32'h0) begin n_bad++; $display("FAIL reset_addr_dout4 got %h want 0", {addr_m4, dout_m4}); end
        n_cmp++; if (din_a4 !== {4{16'hBEEF}}) begin n_bad++; $display("FAIL reset_din_a4 got %h want %h", din_a4, {4{16'hBEEF}}); end
        n_cmp++; if (din_a3 !== {3{8'h3C}}) begin n_bad++; $display("FAIL reset_din_a3 got %h want %h", din_a3, {3{8'h3C}}); end
        n_cmp++; if (gnt_a3 !== 3'b000) begin n_bad++; $display("FAIL reset_gnt3 got %b want 000", gnt_a3); end
        // rdy_m while idle with no request must be ignored
        rdy_m4 = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if ({gnt_a4, rdy_a4} !== 8'h00) begin n_bad++; $display("FAIL idle_rdy_ignored got %h want 00", {gnt_a4, rdy_a4}); end
        rdy_m4 = 1'b0;
    endtask

    task automatic test_rr_order;
        int e;
        do_reset;
        exp_q = {0, 1, 2, 3, 0};
        req_a4 = 4'b1111;
        #1;
        n_cmp++; if (gnt_a4 !== 4'b0000) begin n_bad++; $display("FAIL rr4_same_cycle got %b want 0000", gnt_a4); end
        for (int t = 0; t < 5; t++) begin
            @(negedge clk); #1;
            e = exp_q[0];
            n_cmp++; if (gnt_a4 !== 4'(1 << e)) begin n_bad++; $display("FAIL rr4_gnt[%0d] got %b want %b", t, gnt_a4, 4'(1 << e)); end
            rdy_m4 = 1'b1; #1;
            if (rdy_a4 != 4'b0000) begin
                e = exp_q.pop_front();
                n_cmp++; if (rdy_a4 !== 4'(1 << e)) begin n_bad++; $display("FAIL rr4_rdy[%0d] got %b want %b", t, rdy_a4, 4'(1 << e)); end
            end else begin
                n_cmp++; n_bad++; $display("FAIL rr4_rdy[%0d] got 0000 want one-hot", t);
                void'(exp_q.pop_front());
            end
            @(negedge clk); rdy_m4 = 1'b0; #1;
            n_cmp++; if (gnt_a4 !== 4'b0000) begin n_bad++; $display("FAIL rr4_bubble[%0d] got %b want 0000", t, gnt_a4); end
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rr4_queue got %0d left want 0", exp_q.size()); end
        req_a4 = '0;
    endtask

    task automatic test_wrap3;
        int e;
        do_reset;
        exp_q = {0, 2, 0};
        req_a3 = 3'b101;
        for (int t = 0; t < 3; t++) begin
            @(negedge clk); #1;
            e = exp_q[0];
            n_cmp++; if (gnt_a3 !== 3'(1 << e)) begin n_bad++; $display("FAIL wrap3_gnt[%0d] got %b want %b", t, gnt_a3, 3'(1 << e)); end
            rdy_m3 = 1'b1; #1;
            e = exp_q.pop_front();
            n_cmp++; if (rdy_a3 !== 3'(1 << e)) begin n_bad++; $display("FAIL wrap3_rdy[%0d] got %b want %b", t, rdy_a3, 3'(1 << e)); end
            @(negedge clk); rdy_m3 = 1'b0;
        end
        req_a3 = '0;
    endtask

    task automatic test_mux;
        do_reset;
        addr_a4 = {16'h4444, 16'h3333, 16'h1234, 16'h1111};
        dout_a4 = {16'hD3D3, 16'hD2D2, 16'hA5A5, 16'hD0D0};
        wr_a4   = 4'b0010;
        req_a4  = 4'b0010;
        @(negedge clk); #1;
        n_cmp++; if (gnt_a4 !== 4'b0010) begin n_bad++; $display("FAIL mux_gnt got %b want 0010", gnt_a4); end
        n_cmp++; if (addr_m4 !== 16'h1234) begin n_bad++; $display("FAIL mux_addr got %h want 1234", addr_m4); end
        n_cmp++; if (dout_m4 !== 16'hA5A5) begin n_bad++; $display("FAIL mux_dout got %h want a5a5", dout_m4); end
        n_cmp++; if ({req_m4, wr_m4} !== 2'b11) begin n_bad++; $display("FAIL mux_req_wr got %b want 11", {req_m4, wr_m4}); end
        din_m4 = 16'h5A5A;
        rdy_m4 = 1'b1; #1;
        n_cmp++; if (rdy_a4 !== 4'b0010) begin n_bad++; $display("FAIL mux_rdy got %b want 0010", rdy_a4); end
        n_cmp++; if (din_a4[DW4 +: DW4] !== 16'h5A5A) begin n_bad++; $display("FAIL mux_din got %h want 5a5a", din_a4[DW4 +: DW4]); end
        @(negedge clk);
        rdy_m4 = 1'b0; req_a4 = '0; wr_a4 = '0; #1;
        n_cmp++; if ({gnt_a4, addr_m4} !== 20'h0) begin n_bad++; $display("FAIL mux_idle got %h want 0", {gnt_a4, addr_m4}); end
    endtask

    // Runs right after test_mux, so last = 1.
    task automatic test_withdraw;
        req_a4 = 4'b0100;
        @(negedge clk); #1;
        n_cmp++; if (gnt_a4 !== 4'b0100) begin n_bad++; $display("FAIL wd_gnt got %b want 0100", gnt_a4); end
        req_a4 = 4'b0000; #1;
        n_cmp++; if ({req_m4, rdy_a4} !== 5'b0) begin n_bad++; $display("FAIL wd_drop got %b want 00000", {req_m4, rdy_a4}); end
        @(negedge clk); #1;
        n_cmp++; if ({gnt_a4, rdy_a4} !== 8'h00) begin n_bad++; $display("FAIL wd_idle got %h want 00", {gnt_a4, rdy_a4}); end
        req_a4 = 4'b1111;
        @(negedge clk); #1;
        // last was not advanced by the withdrawal, so scanning restarts at 2
        n_cmp++; if (gnt_a4 !== 4'b0100) begin n_bad++; $display("FAIL wd_regrant got %b want 0100", gnt_a4); end
        rdy_m4 = 1'b1; #1;
        n_cmp++; if (rdy_a4 !== 4'b0100) begin n_bad++; $display("FAIL wd_rdy got %b want 0100", rdy_a4); end
        @(negedge clk); rdy_m4 = 1'b0; req_a4 = '0;
    endtask

`ifdef ARB_TIMEOUT_EN
    task automatic test_timeout;
        do_reset;
        req_a4 = 4'b0010;
        @(negedge clk); #1;
        for (int k = 1; k < TO; k++) begin
            n_cmp++; if ({gnt_a4, err_a4} !== 8'b0010_0000) begin n_bad++; $display("FAIL to_wait[%0d] got %b want 00100000", k, {gnt_a4, err_a4}); end
            @(negedge clk); #1;
        end
        n_cmp++; if ({err_a4, req_m4, rdy_a4} !== 9'b0010_1_0000) begin n_bad++; $display("FAIL to_err got %b want 001010000", {err_a4, req_m4, rdy_a4}); end
        @(negedge clk); #1;
        n_cmp++; if ({gnt_a4, err_a4} !== 8'h00) begin n_bad++; $display("FAIL to_idle got %h want 00", {gnt_a4, err_a4}); end
        @(negedge clk); #1;
        for (int k = 1; k < TO; k++) @(negedge clk);
        rdy_m4 = 1'b1; #1;
        n_cmp++; if ({rdy_a4, err_a4} !== 8'b0010_0000) begin n_bad++; $display("FAIL to_rdy_wins got %b want 00100000", {rdy_a4, err_a4}); end
        @(negedge clk); rdy_m4 = 1'b0; req_a4 = '0;
    endtask
`else
    task automatic test_timeout;
        do_reset;
        req_a4 = 4'b0010;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); #1;
            n_cmp++; if ({gnt_a4, err_a4} !== 8'b0010_0000) begin n_bad++; $display("FAIL noto_hold[%0d] got %b want 00100000", k, {gnt_a4, err_a4}); end
        end
        rdy_m4 = 1'b1; #1;
        n_cmp++; if (rdy_a4 !== 4'b0010) begin n_bad++; $display("FAIL noto_rdy got %b want 0010", rdy_a4); end
        @(negedge clk); rdy_m4 = 1'b0; req_a4 = '0;
    endtask
`endif

    task automatic test_async_reset;
        do_reset;
        req_a4 = 4'b0100;
        @(negedge clk); #1;
        n_cmp++; if (gnt_a4 !== 4'b0100) begin n_bad++; $display("FAIL ar_gnt got %b want 0100", gnt_a4); end
        #2 rst_n = 1'b0;
        #1;
        n_cmp++; if ({gnt_a4, req_m4} !== 5'b0) begin n_bad++; $display("FAIL ar_drop got %b want 00000", {gnt_a4, req_m4}); end
        req_a4 = 4'b1111;
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk); #1;
        n_cmp++; if (gnt_a4 !== 4'b0001) begin n_bad++; $display("FAIL ar_first got %b want 0001", gnt_a4); end
        rdy_m4 = 1'b1;
        @(negedge clk); rdy_m4 = 1'b0; req_a4 = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        test_reset;
        test_rr_order;
        test_wrap3;
        test_mux;
        test_withdraw;
        test_timeout;
        test_async_reset;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
